// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU sequencer.
//   - DATA_W     : operand / result width
//   - MUL_ITERS  : shift-add iterations for a multiply
//   - OP_*       : opcode encodings presented on req_op / alu_ctl
//   - state_t    : sequencer FSM state encoding
// Optional feature macro: ALU_SEQ_MUL_EN (adds the iterative MUL state).
package alu_seq_pkg;

  localparam int DATA_W    = 32;
  localparam int MUL_ITERS = 32;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_SLLV = 3'b101;
  localparam logic [2:0] OP_SRAV = 3'b110;
  localparam logic [2:0] OP_SRLV = 3'b111;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/alu_seq_mul_dp.sv
// alu_seq_mul_dp: multiplicand/multiplier shift registers and iteration
// counter for the shift-add multiply. Only compiled with ALU_SEQ_MUL_EN.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_load        : initialise from i_a / i_b (request accept with MUL op)
//   i_step        : one multiply iteration happens at this edge
//   i_a, i_b      : multiplicand / multiplier at load time
//   o_alu_b       : addend for this iteration (mcand when mplier LSB set)
//   o_last        : current iteration is the final one
`ifdef ALU_SEQ_MUL_EN
module alu_seq_mul_dp
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_alu_b,
  output logic              o_last
);

  localparam int CNT_W = $clog2(MUL_ITERS);

  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [CNT_W-1:0]  r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (i_load) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_count  <= '0;
    end else if (i_step) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
    end
  end

  assign o_alu_b = r_mplier[0] ? r_mcand : '0;
  // No early exit on a zero multiplier: always run all iterations.
  assign o_last  = (r_count == CNT_W'(MUL_ITERS - 1));

endmodule
`endif

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU request at a time, drives a shared external
// combinational ALU and returns the captured result with flags.
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   req_valid/req_ready     : request handshake; req_a, req_b, req_op payload
//   rsp_valid/rsp_ready     : response handshake; rsp_out + zero/overflow/
//                             cout/err flags
//   alu_a, alu_b, alu_ctl   : drive to the shared ALU
//   alu_out, alu_zero, alu_overflow, alu_cout : same-cycle ALU results
//   dbg_state               : current FSM state for observation
// Handshake: a transfer occurs on a rising clk edge where valid and ready are
// both high; valid never depends on ready, and the response payload is held
// stable while rsp_valid is high and rsp_ready is low.
// Optional feature macro: ALU_SEQ_MUL_EN (iterative shift-add MUL). Without it
// op MUL completes in one cycle with rsp_err=1 and rsp_out=0.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [2:0]        req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_out,
  output logic              rsp_zero,
  output logic              rsp_overflow,
  output logic              rsp_cout,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctl,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_cout,
  output state_t            dbg_state
);

  state_t r_state, w_state_nxt;

  logic [DATA_W-1:0] r_a, r_b;
  logic [2:0]        r_op;
  logic              w_accept;
  logic              w_exec_cap;

`ifdef ALU_SEQ_MUL_EN
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_mul_b;
  logic              w_mul_load;
  logic              w_mul_step;
  logic              w_mul_last;

  alu_seq_mul_dp u_mul_dp (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_mul_load),
    .i_step  (w_mul_step),
    .i_a     (req_a),
    .i_b     (req_b),
    .o_alu_b (w_mul_b),
    .o_last  (w_mul_last)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_ctl     = OP_ADD;
    w_accept    = 1'b0;
    w_exec_cap  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    w_mul_load  = 1'b0;
    w_mul_step  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
`ifdef ALU_SEQ_MUL_EN
          if (req_op == OP_MUL) begin
            w_mul_load  = 1'b1;
            w_state_nxt = ST_MUL;
          end else begin
            w_state_nxt = ST_EXEC;
          end
`else
          w_state_nxt = ST_EXEC;
`endif
        end
      end
      ST_EXEC: begin
        // An unsupported MUL leaves the ALU at its idle drive.
        if (r_op != OP_MUL) begin
          alu_a   = r_a;
          alu_b   = r_b;
          alu_ctl = r_op;
        end
        w_exec_cap  = 1'b1;
        w_state_nxt = ST_RESP;
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        alu_a      = r_acc;
        alu_b      = w_mul_b;
        w_mul_step = 1'b1;
        if (w_mul_last) w_state_nxt = ST_RESP;
      end
`endif
      ST_RESP: begin
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= OP_ADD;
    end else if (w_accept) begin
      r_a  <= req_a;
      r_b  <= req_b;
      r_op <= req_op;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_acc <= '0;
    else if (w_mul_load) r_acc <= '0;
    else if (w_mul_step) r_acc <= alu_out;
  end
`endif

  // Response registers: written only on the capture edge, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_out      <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_cout     <= 1'b0;
      rsp_err      <= 1'b0;
    end else if (w_exec_cap) begin
      if (r_op == OP_MUL) begin
        rsp_out      <= '0;
        rsp_zero     <= 1'b1;
        rsp_overflow <= 1'b0;
        rsp_cout     <= 1'b0;
        rsp_err      <= 1'b1;
      end else begin
        rsp_out      <= alu_out;
        rsp_zero     <= alu_zero;
        rsp_overflow <= alu_overflow;
        rsp_cout     <= alu_cout;
        rsp_err      <= 1'b0;
      end
    end
`ifdef ALU_SEQ_MUL_EN
    else if (w_mul_step && w_mul_last) begin
      rsp_out      <= alu_out;
      rsp_zero     <= (alu_out == '0);
      rsp_overflow <= 1'b0;
      rsp_cout     <= 1'b0;
      rsp_err      <= 1'b0;
    end
`endif
  end

  assign rsp_valid = (r_state == ST_RESP);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer. Models
// the shared combinational ALU that the parent would instantiate.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0, req_b = '0;
  logic [2:0]  req_op = OP_ADD;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_out;
  logic        rsp_zero, rsp_overflow, rsp_cout, rsp_err;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_ctl;
  logic        alu_zero, alu_overflow, alu_cout;
  state_t      dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- ALU model ----------------
  logic [32:0] m_sum;
  always_comb begin
    m_sum        = '0;
    alu_out      = '0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_ctl)
      OP_ADD: begin
        m_sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out      = m_sum[31:0];
        alu_cout     = m_sum[32];
        alu_overflow = (alu_a[31] == alu_b[31]) && (m_sum[31] != alu_a[31]);
      end
      OP_SUB: begin
        m_sum        = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_out      = m_sum[31:0];
        alu_cout     = m_sum[32];
        alu_overflow = (alu_a[31] != alu_b[31]) && (m_sum[31] != alu_a[31]);
      end
      OP_XOR:  alu_out = alu_a ^ alu_b;
      OP_SLT:  alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      OP_SLLV: alu_out = alu_a << alu_b[4:0];
      OP_SRAV: alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      OP_SRLV: alu_out = alu_a >> alu_b[4:0];
      default: alu_out = '0;
    endcase
  end
  assign alu_zero = (alu_out == 32'd0);

  alu_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_out      (rsp_out),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_cout     (rsp_cout),
    .rsp_err      (rsp_err),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctl      (alu_ctl),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .alu_cout     (alu_cout),
    .dbg_state    (dbg_state)
  );

  // ---------------- driver ----------------
  // Presents one request from IDLE, then counts edges after the accept edge
  // until rsp_valid is seen (-1 on timeout). Tracks any nonzero alu_ctl seen
  // while waiting.
  task automatic do_req(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, output int lat,
                        output logic ctl_bad);
    @(negedge clk);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1;
    ctl_bad = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (alu_ctl !== 3'b000) ctl_bad = 1'b1;
      @(posedge clk);
      #1;
      if (rsp_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
    n_vec++; if ({rsp_out, rsp_zero, rsp_overflow, rsp_cout, rsp_err} !== 36'd0) begin n_err++; $display("FAIL reset_rsp got %h z%0b o%0b c%0b e%0b want 0", rsp_out, rsp_zero, rsp_overflow, rsp_cout, rsp_err); end
    n_vec++; if ({alu_a, alu_b, alu_ctl} !== 67'd0) begin n_err++; $display("FAIL reset_alu got a=%h b=%h ctl=%0d want 0", alu_a, alu_b, alu_ctl); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_overflow();
    int lat; logic cb;
    rsp_ready = 1'b1;
    do_req(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, lat, cb);
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL add_latency got %0d want 1", lat); end
    n_vec++; if (rsp_out !== 32'h8000_0000) begin n_err++; $display("FAIL add_out got %h want 80000000", rsp_out); end
    n_vec++; if ({rsp_overflow, rsp_cout, rsp_zero, rsp_err} !== 4'b1000) begin n_err++; $display("FAIL add_flags got o%0b c%0b z%0b e%0b want o1 c0 z0 e0", rsp_overflow, rsp_cout, rsp_zero, rsp_err); end
    @(posedge clk); #1;
    n_vec++; if (dbg_state !== ST_IDLE || rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_to_idle got state=%0d rsp_valid=%0b want 0/0", dbg_state, rsp_valid); end
  endtask

  task automatic test_sub_hold();
    int lat; logic cb; logic bad;
    rsp_ready = 1'b0;
    do_req(32'd5, 32'd5, OP_SUB, lat, cb);
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL sub_latency got %0d want 1", lat); end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      // Stray request traffic while busy must be ignored.
      req_valid = i[0]; req_a = 32'h1234_5678; req_op = OP_XOR;
      if (rsp_valid !== 1'b1 || rsp_out !== 32'd0 || rsp_zero !== 1'b1 || req_ready !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    n_vec++; if (bad) begin n_err++; $display("FAIL sub_hold got unstable response or req_ready high want held 0/zero=1"); end
    n_vec++; if (rsp_out !== 32'd0 || rsp_zero !== 1'b1 || rsp_cout !== 1'b1) begin n_err++; $display("FAIL sub_result got %h z%0b c%0b want 0 z1 c1", rsp_out, rsp_zero, rsp_cout); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (dbg_state !== ST_IDLE || req_ready !== 1'b1) begin n_err++; $display("FAIL sub_to_idle got state=%0d req_ready=%0b want IDLE/1", dbg_state, req_ready); end
  endtask

  task automatic test_back_to_back();
    int lat; logic cb;
    rsp_ready = 1'b1;
    do_req(32'd1, 32'd2, OP_ADD, lat, cb);
    n_vec++; if (lat != 1 || rsp_out !== 32'd3) begin n_err++; $display("FAIL b2b_first got lat=%0d out=%h want 1/3", lat, rsp_out); end
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_in_resp got %0b want 0", req_ready); end
    // Offer the next request during the response handshake cycle.
    req_a = 32'hF0F0_F0F0; req_b = 32'h0FF0_0FF0; req_op = OP_XOR; req_valid = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle got rsp_valid=%0b req_ready=%0b want 0/1", rsp_valid, req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_second_accept got req_ready=%0b want 0", req_ready); end
    @(posedge clk); #1;
    n_vec++; if (rsp_valid !== 1'b1 || rsp_out !== 32'hFF00_FF00) begin n_err++; $display("FAIL b2b_second got valid=%0b out=%h want 1/ff00ff00", rsp_valid, rsp_out); end
    @(posedge clk); #1;
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic test_mul();
    int lat; logic cb;
    rsp_ready = 1'b1;
    do_req(32'h0001_0001, 32'h0001_0001, OP_MUL, lat, cb);
    n_vec++; if (lat != 32) begin n_err++; $display("FAIL mul_latency got %0d want 32", lat); end
    n_vec++; if (rsp_out !== 32'h0002_0001 || rsp_err !== 1'b0) begin n_err++; $display("FAIL mul_out got %h err=%0b want 00020001/0", rsp_out, rsp_err); end
    n_vec++; if (cb !== 1'b0) begin n_err++; $display("FAIL mul_alu_ctl got nonzero want 000 throughout"); end
    @(posedge clk); #1;
    do_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MUL, lat, cb);
    n_vec++; if (lat != 32 || rsp_out !== 32'h0000_0001 || rsp_overflow !== 1'b0 || rsp_cout !== 1'b0) begin n_err++; $display("FAIL mul_wrap got lat=%0d out=%h o%0b c%0b want 32/1/0/0", lat, rsp_out, rsp_overflow, rsp_cout); end
    @(posedge clk); #1;
    do_req(32'h0001_0000, 32'h0001_0000, OP_MUL, lat, cb);
    n_vec++; if (lat != 32 || rsp_out !== 32'd0 || rsp_zero !== 1'b1) begin n_err++; $display("FAIL mul_zero got lat=%0d out=%h z%0b want 32/0/1", lat, rsp_out, rsp_zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int lat; logic cb; logic seen;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_a = 32'd7; req_b = 32'd9; req_op = OP_MUL; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL abort_immediate got ready=%0b valid=%0b state=%0d want 1/0/IDLE", req_ready, rsp_valid, dbg_state); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    n_vec++; if (seen) begin n_err++; $display("FAIL abort_no_rsp got rsp_valid high want never"); end
    do_req(32'd2, 32'd3, OP_ADD, lat, cb);
    n_vec++; if (lat != 1 || rsp_out !== 32'd5) begin n_err++; $display("FAIL abort_next_add got lat=%0d out=%h want 1/5", lat, rsp_out); end
    @(posedge clk); #1;
  endtask
`else
  task automatic test_mul_disabled();
    int lat; logic cb;
    rsp_ready = 1'b1;
    do_req(32'd3, 32'd4, OP_MUL, lat, cb);
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL nomul_latency got %0d want 1", lat); end
    n_vec++; if (rsp_out !== 32'd0 || {rsp_zero, rsp_overflow, rsp_cout, rsp_err} !== 4'b1001) begin n_err++; $display("FAIL nomul_rsp got %h z%0b o%0b c%0b e%0b want 0 z1 o0 c0 e1", rsp_out, rsp_zero, rsp_overflow, rsp_cout, rsp_err); end
    n_vec++; if (cb !== 1'b0) begin n_err++; $display("FAIL nomul_alu_drive got nonzero alu_ctl want 000"); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int lat; logic cb;
    rsp_ready = 1'b0;
    do_req(32'd7, 32'd9, OP_ADD, lat, cb);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_out !== 32'd0) begin n_err++; $display("FAIL abort_immediate got ready=%0b valid=%0b out=%h want 1/0/0", req_ready, rsp_valid, rsp_out); end
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    do_req(32'd2, 32'd3, OP_ADD, lat, cb);
    n_vec++; if (lat != 1 || rsp_out !== 32'd5) begin n_err++; $display("FAIL abort_next_add got lat=%0d out=%h want 1/5", lat, rsp_out); end
    @(posedge clk); #1;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_add_overflow();
    test_sub_hold();
    test_back_to_back();
`ifdef ALU_SEQ_MUL_EN
    test_mul();
`else
    test_mul_disabled();
`endif
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
